quad_uart: RTL and testbench

- Four independent, simplified 16550-style UART channels behind a single 32-bit Wishbone slave port, with one interrupt line per channel.
- Sits between the system Wishbone bus and four serial ports.
- Fixed frame format: 8 data bits, no parity, 1 stop bit, 16x oversampling.
- No FIFOs: one transmit holding byte and one receive buffer byte per channel.

---
 rtl/quad_uart_pkg.sv | 35 +++
 rtl/quad_uart_channel.sv | 257 +++++++++++++++++++++++++
 rtl/quad_uart.sv | 96 +++++++++
 tb/tb_quad_uart.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/quad_uart_pkg.sv
// quad_uart_pkg: shared definitions for the quad UART.
// Holds the register offsets, IIR codes, LSR bit indices and the receiver
// state encoding used by quad_uart and quad_uart_channel.
package quad_uart_pkg;

    // Register offsets within one channel (byte address bits [4:2])
    localparam logic [2:0] REG_RBR_THR = 3'd0;  // DLL when DLAB = 1
    localparam logic [2:0] REG_IER     = 3'd1;  // DLM when DLAB = 1
    localparam logic [2:0] REG_IIR     = 3'd2;
    localparam logic [2:0] REG_LCR     = 3'd3;
    localparam logic [2:0] REG_MCR     = 3'd4;
    localparam logic [2:0] REG_LSR     = 3'd5;
    localparam logic [2:0] REG_MSR     = 3'd6;

    // IIR codes, highest priority first
    localparam logic [7:0] IIR_LINE   = 8'h06;
    localparam logic [7:0] IIR_RXDATA = 8'h04;
    localparam logic [7:0] IIR_THRE   = 8'h02;
    localparam logic [7:0] IIR_NONE   = 8'h01;

    // LSR bit positions
    localparam int LSR_DR   = 0;
    localparam int LSR_OE   = 1;
    localparam int LSR_FE   = 3;
    localparam int LSR_THRE = 5;
    localparam int LSR_TEMT = 6;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

endpackage

// File: rtl/quad_uart_channel.sv
// quad_uart_channel: one simplified 16550-style UART channel.
// Contains the register file, the baud engine, the transmitter and the
// receiver. Fixed 8N1 framing with 16 ticks per bit.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   rd, wr           one-cycle register access strobes (the bus ack cycle)
//   addr, wdat       register offset and write data
//   rdat             read value of the addressed register (combinational)
//   rx               serial in (asynchronous, synchronised here)
//   cts, dsr, ri, dcd  modem inputs, active-low
//   tx               serial out
//   rts, dtr         modem outputs, active-low
//   irq              registered interrupt, high while IIR[0] = 0
module quad_uart_channel
    import quad_uart_pkg::*;
#(
    parameter logic [15:0] DIV_RESET = 16'd0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rd,
    input  logic       wr,
    input  logic [2:0] addr,
    input  logic [7:0] wdat,
    output logic [7:0] rdat,
    input  logic       rx,
    input  logic       cts,
    input  logic       dsr,
    input  logic       ri,
    input  logic       dcd,
    output logic       tx,
    output logic       rts,
    output logic       dtr,
    output logic       irq
);

    logic       dlab;
    logic [2:0] ier;
    logic [1:0] mcr;
    logic [7:0] dll, dlm, thr, rbr;
    logic       thre, thre_int, dr, oe, fe;
    logic [7:0] lsr, iir, msr;

    // Decoded access strobes
    logic wr_thr, wr_dll, wr_dlm, rd_rbr, rd_lsr, rd_iir;
    assign wr_thr = wr && addr == REG_RBR_THR && !dlab;
    assign wr_dll = wr && addr == REG_RBR_THR && dlab;
    assign wr_dlm = wr && addr == REG_IER && dlab;
    assign rd_rbr = rd && addr == REG_RBR_THR && !dlab;
    assign rd_lsr = rd && addr == REG_LSR;
    assign rd_iir = rd && addr == REG_IIR;

    // ---------------- Baud engine ----------------
    logic [15:0] baud_cnt, div_new;
    logic        tick;

    always_comb begin
        div_new = {dlm, dll};
        if (wr_dll) div_new[7:0]  = wdat;
        if (wr_dlm) div_new[15:8] = wdat;
    end

    // A zero divisor never ticks, which halts tx and rx.
    assign tick = ({dlm, dll} != 16'd0) && (baud_cnt == 16'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 baud_cnt <= DIV_RESET - 16'd1;
        else if (wr_dll || wr_dlm)  baud_cnt <= div_new - 16'd1;
        else if (tick)              baud_cnt <= {dlm, dll} - 16'd1;
        else if (baud_cnt != 16'd0) baud_cnt <= baud_cnt - 16'd1;
    end

    // ---------------- Transmitter ----------------
    logic       tx_busy, tx_load;
    logic [9:0] tx_sh;
    logic [3:0] tx_tcnt, tx_bcnt;

    // A THR write in the same cycle wins; the new byte loads on a later tick.
    assign tx_load = tick && !tx_busy && !thre && !wr_thr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_busy <= 1'b0;
            tx_sh   <= 10'h3FF;
            tx_tcnt <= 4'd0;
            tx_bcnt <= 4'd0;
        end else if (tx_load) begin
            tx_busy <= 1'b1;
            tx_sh   <= {1'b1, thr, 1'b0};
            tx_tcnt <= 4'd0;
            tx_bcnt <= 4'd0;
        end else if (tx_busy && tick) begin
            if (tx_tcnt == 4'd15) begin
                tx_tcnt <= 4'd0;
                tx_sh   <= {1'b1, tx_sh[9:1]};
                if (tx_bcnt == 4'd9) tx_busy <= 1'b0;
                else                 tx_bcnt <= tx_bcnt + 4'd1;
            end else begin
                tx_tcnt <= tx_tcnt + 4'd1;
            end
        end
    end

    assign tx = tx_busy ? tx_sh[0] : 1'b1;

    // ---------------- Receiver ----------------
    logic       rx_m, rx_s, rx_d;
    rx_state_t  rx_state, rx_next;
    logic [3:0] rx_tcnt, rx_target;
    logic [2:0] rx_bcnt;
    logic [7:0] rx_sh;
    logic       rx_at, rx_shift, rx_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
            rx_d <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
            rx_d <= rx_s;
        end
    end

    // Start bit is checked at its 8th tick; later bits every 16 ticks.
    assign rx_target = (rx_state == RX_START) ? 4'd7 : 4'd15;
    assign rx_at     = tick && (rx_tcnt == rx_target);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rx_state <= RX_IDLE;
        else        rx_state <= rx_next;
    end

    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            RX_IDLE:  if (rx_d && !rx_s) rx_next = RX_START;
            RX_START: if (rx_at) rx_next = rx_s ? RX_IDLE : RX_DATA;
            RX_DATA:  if (rx_at && rx_bcnt == 3'd7) rx_next = RX_STOP;
            RX_STOP:  if (rx_at) rx_next = RX_IDLE;
            default:  rx_next = RX_IDLE;
        endcase
    end

    always_comb begin
        rx_shift = 1'b0;
        rx_done  = 1'b0;
        case (rx_state)
            RX_DATA: rx_shift = rx_at;
            RX_STOP: rx_done  = rx_at;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_tcnt <= 4'd0;
            rx_bcnt <= 3'd0;
            rx_sh   <= 8'd0;
        end else begin
            if (rx_state == RX_IDLE || rx_at) rx_tcnt <= 4'd0;
            else if (tick)                    rx_tcnt <= rx_tcnt + 4'd1;
            if (rx_state != RX_DATA) rx_bcnt <= 3'd0;
            else if (rx_shift)       rx_bcnt <= rx_bcnt + 3'd1;
            if (rx_shift) rx_sh <= {rx_s, rx_sh[7:1]};
        end
    end

    // ---------------- Register file ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dlab     <= 1'b0;
            ier      <= 3'd0;
            mcr      <= 2'd0;
            dll      <= DIV_RESET[7:0];
            dlm      <= DIV_RESET[15:8];
            thr      <= 8'd0;
            thre     <= 1'b1;
            thre_int <= 1'b0;
            rbr      <= 8'd0;
            dr       <= 1'b0;
            oe       <= 1'b0;
            fe       <= 1'b0;
            irq      <= 1'b0;
        end else begin
            if (wr_dll) dll <= wdat;
            if (wr_dlm) dlm <= wdat;
            if (wr && addr == REG_IER && !dlab) ier <= wdat[2:0];
            if (wr && addr == REG_LCR) dlab <= wdat[7];
            if (wr && addr == REG_MCR) mcr <= wdat[1:0];

            if (wr_thr) begin
                thr      <= wdat;
                thre     <= 1'b0;
                thre_int <= 1'b0;
            end else if (tx_load) begin
                thre     <= 1'b1;
                thre_int <= 1'b1;
            end else if (rd_iir && iir == IIR_THRE) begin
                thre_int <= 1'b0;
            end

            // A completing frame takes precedence over a same-cycle read.
            if (rx_done) begin
                rbr <= rx_sh;
                dr  <= 1'b1;
                oe  <= dr | (oe & !rd_lsr);
                fe  <= !rx_s | (fe & !rd_lsr);
            end else begin
                if (rd_rbr) dr <= 1'b0;
                if (rd_lsr) begin
                    oe <= 1'b0;
                    fe <= 1'b0;
                end
            end

            irq <= !iir[0];
        end
    end

    always_comb begin
        lsr           = 8'd0;
        lsr[LSR_DR]   = dr;
        lsr[LSR_OE]   = oe;
        lsr[LSR_FE]   = fe;
        lsr[LSR_THRE] = thre;
        lsr[LSR_TEMT] = thre && !tx_busy;
    end

    always_comb begin
        if (ier[2] && (oe || fe))   iir = IIR_LINE;
        else if (ier[0] && dr)      iir = IIR_RXDATA;
        else if (ier[1] && thre_int) iir = IIR_THRE;
        else                        iir = IIR_NONE;
    end

    assign msr = {~dcd, ~ri, ~dsr, ~cts, 4'b0000};
    assign dtr = ~mcr[0];
    assign rts = ~mcr[1];

    always_comb begin
        rdat = 8'd0;
        case (addr)
            REG_RBR_THR: rdat = dlab ? dll : rbr;
            REG_IER:     rdat = dlab ? dlm : {5'd0, ier};
            REG_IIR:     rdat = iir;
            REG_LCR:     rdat = {dlab, 7'd0};
            REG_MCR:     rdat = {6'd0, mcr};
            REG_LSR:     rdat = lsr;
            REG_MSR:     rdat = msr;
            default:     rdat = 8'd0;
        endcase
    end

endmodule

// File: rtl/quad_uart.sv
// quad_uart: four UART channels behind one 32-bit Wishbone slave.
// Address bits [6:5] pick the channel, [4:2] the register. Vector bit
// [3-n] of every serial/modem/interrupt port belongs to channel n.
//
// Handshake: a request (cyc & stb) seen while ack is low is captured and
// acknowledged for exactly one cycle on the next edge; a held strobe is
// therefore acked every other cycle. Read data is driven only during ack,
// and register side effects take place at the edge closing the ack cycle.
// A write only takes effect when wb_sel_i[0] is set.
//
// Ports: Wishbone slave (wb_*), uart_tx/rx serial lines, uart_rts/dtr
// modem outputs, uart_cts/dsr/ri/dcd modem inputs, uart_int interrupts.
module quad_uart
    import quad_uart_pkg::*;
#(
    parameter int          NUM_CH    = 4,
    parameter logic [15:0] DIV_RESET = 16'd0
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    input  logic        wb_we_i,
    input  logic        wb_stb_i,
    input  logic        wb_cyc_i,
    input  logic [3:0]  wb_sel_i,
    output logic        wb_ack_o,
    output logic [3:0]  uart_tx,
    input  logic [3:0]  uart_rx,
    output logic [3:0]  uart_rts,
    input  logic [3:0]  uart_cts,
    output logic [3:0]  uart_dtr,
    input  logic [3:0]  uart_dsr,
    input  logic [3:0]  uart_ri,
    input  logic [3:0]  uart_dcd,
    output logic [3:0]  uart_int
);

    logic [1:0] ch_q;
    logic [2:0] reg_q;
    logic       we_q, sel_q;
    logic [7:0] wdat_q;
    logic [7:0] ch_rdat [NUM_CH];

    logic unused_bits;
    assign unused_bits = &{1'b0, wb_adr_i[31:7], wb_adr_i[1:0],
                           wb_dat_i[31:8], wb_sel_i[3:1]};

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            wb_ack_o <= 1'b0;
            ch_q     <= 2'd0;
            reg_q    <= 3'd0;
            we_q     <= 1'b0;
            sel_q    <= 1'b0;
            wdat_q   <= 8'd0;
        end else begin
            wb_ack_o <= wb_cyc_i && wb_stb_i && !wb_ack_o;
            if (wb_cyc_i && wb_stb_i && !wb_ack_o) begin
                ch_q   <= wb_adr_i[6:5];
                reg_q  <= wb_adr_i[4:2];
                we_q   <= wb_we_i;
                sel_q  <= wb_sel_i[0];
                wdat_q <= wb_dat_i[7:0];
            end
        end
    end

    assign wb_dat_o = wb_ack_o ? {24'd0, ch_rdat[ch_q]} : 32'd0;

    for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
        logic hit;
        assign hit = wb_ack_o && (ch_q == 2'(n));

        quad_uart_channel #(.DIV_RESET(DIV_RESET)) u_ch (
            .clk   (wb_clk_i),
            .rst_n (wb_rst_i),
            .rd    (hit && !we_q),
            .wr    (hit && we_q && sel_q),
            .addr  (reg_q),
            .wdat  (wdat_q),
            .rdat  (ch_rdat[n]),
            .rx    (uart_rx[3-n]),
            .cts   (uart_cts[3-n]),
            .dsr   (uart_dsr[3-n]),
            .ri    (uart_ri[3-n]),
            .dcd   (uart_dcd[3-n]),
            .tx    (uart_tx[3-n]),
            .rts   (uart_rts[3-n]),
            .dtr   (uart_dtr[3-n]),
            .irq   (uart_int[3-n])
        );
    end

endmodule

// File: tb/tb_quad_uart.sv
// tb_quad_uart: directed self-checking bench for quad_uart.
module tb_quad_uart;

    logic        clk;
    logic        rst_n;
    logic [31:0] adr, dat_i;
    logic [31:0] dat_o;
    logic        we, stb, cyc;
    logic [3:0]  sel;
    logic        ack;
    logic [3:0]  tx, rts, dtr, irq;
    logic [3:0]  rx_drv, cts, dsr, ri, dcd;
    logic        lb;
    logic [3:0]  rx;

    int tests = 0;
    int fails = 0;

    // Loopback ties channel 2 (bit 1) tx back to its rx.
    assign rx = lb ? {rx_drv[3:2], tx[1], rx_drv[0]} : rx_drv;

    quad_uart dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst_n),
        .wb_adr_i (adr),
        .wb_dat_i (dat_i),
        .wb_dat_o (dat_o),
        .wb_we_i  (we),
        .wb_stb_i (stb),
        .wb_cyc_i (cyc),
        .wb_sel_i (sel),
        .wb_ack_o (ack),
        .uart_tx  (tx),
        .uart_rx  (rx),
        .uart_rts (rts),
        .uart_cts (cts),
        .uart_dtr (dtr),
        .uart_dsr (dsr),
        .uart_ri  (ri),
        .uart_dcd (dcd),
        .uart_int (irq)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic wb_xfer(input int ch, input int rg, input logic w, input logic [7:0] d,
                           input logic [3:0] s, output logic [7:0] q);
        logic got;
        @(posedge clk); #1;
        adr   = {25'd0, 2'(ch), 3'(rg), 2'b00};
        dat_i = {24'd0, d};
        we    = w;
        sel   = s;
        cyc   = 1'b1;
        stb   = 1'b1;
        got   = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            @(posedge clk); #1;
            if (ack) got = 1'b1;
        end
        q   = dat_o[7:0];
        cyc = 1'b0;
        stb = 1'b0;
        we  = 1'b0;
        if (!got) check("ack_timeout", {31'd0, got}, 32'd1);
    endtask

    task automatic wb_write(input int ch, input int rg, input logic [7:0] d);
        logic [7:0] q;
        wb_xfer(ch, rg, 1'b1, d, 4'hF, q);
    endtask

    task automatic wb_read(input int ch, input int rg, output logic [7:0] q);
        wb_xfer(ch, rg, 1'b0, 8'd0, 4'hF, q);
    endtask

    task automatic set_div1(input int ch);
        wb_write(ch, 3, 8'h80);
        wb_write(ch, 0, 8'h01);
        wb_write(ch, 1, 8'h00);
        wb_write(ch, 3, 8'h00);
    endtask

    // Drives one frame on channel 2's rx line at divisor 1 (16 clocks/bit).
    task automatic send_raw(input logic [7:0] d, input logic stop);
        @(posedge clk); #1;
        rx_drv[1] = 1'b0;
        repeat (16) @(posedge clk);
        for (int b = 0; b < 8; b++) begin
            rx_drv[1] = d[b];
            repeat (16) @(posedge clk);
        end
        rx_drv[1] = stop;
        repeat (16) @(posedge clk);
        rx_drv[1] = 1'b1;
        repeat (8) @(posedge clk);
    endtask

    // ---------------- stimulus ----------------
    logic [7:0] q;
    logic [9:0] frame;
    int         cnt;
    logic       seen;

    initial begin
        rst_n  = 1'b0;
        adr    = '0;
        dat_i  = '0;
        we     = 1'b0;
        stb    = 1'b0;
        cyc    = 1'b0;
        sel    = 4'h0;
        rx_drv = 4'hF;
        cts    = 4'hF;
        dsr    = 4'hF;
        ri     = 4'hF;
        dcd    = 4'hF;
        lb     = 1'b0;

        // Reset state
        repeat (3) @(posedge clk); #1;
        check("rst_tx", {28'd0, tx}, 32'hF);
        check("rst_rts", {28'd0, rts}, 32'hF);
        check("rst_dtr", {28'd0, dtr}, 32'hF);
        check("rst_int", {28'd0, irq}, 32'h0);
        check("rst_ack", {31'd0, ack}, 32'h0);
        check("rst_dat", dat_o, 32'h0);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            wb_read(c, 5, q); check($sformatf("rst_lsr%0d", c), {24'd0, q}, 32'h60);
            wb_read(c, 2, q); check($sformatf("rst_iir%0d", c), {24'd0, q}, 32'h01);
        end

        // Channel 0 transmit of A5 (line bit 3)
        set_div1(0);
        wb_write(0, 0, 8'hA5);
        frame = {1'b1, 8'hA5, 1'b0};
        seen  = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(posedge clk); #1;
            if (tx[3] == 1'b0) seen = 1'b1;
        end
        check("tx_start_seen", {31'd0, seen}, 32'd1);
        cnt = 1;
        for (int i = 0; i < 40 && tx[3] == 1'b0; i++) begin
            @(posedge clk); #1;
            if (tx[3] == 1'b0) cnt++;
        end
        check("tx_start_len", cnt, 32'd16);
        repeat (8) @(posedge clk);
        for (int b = 1; b < 10; b++) begin
            check($sformatf("tx_bit%0d", b), {31'd0, tx[3]}, {31'd0, frame[b]});
            if (b < 9) repeat (16) @(posedge clk);
        end
        repeat (16) @(posedge clk);
        wb_read(0, 5, q); check("tx_lsr_done", {24'd0, q}, 32'h60);

        // Channel 2 loopback
        set_div1(2);
        wb_write(2, 1, 8'h01);
        lb = 1'b1;
        wb_write(2, 0, 8'h3C);
        seen = 1'b0;
        for (int i = 0; i < 500 && !seen; i++) begin
            @(posedge clk); #1;
            if (irq[1]) seen = 1'b1;
        end
        check("lb_int_hi", {28'd0, irq}, 32'h2);
        wb_read(2, 2, q); check("lb_iir", {24'd0, q}, 32'h04);
        wb_read(2, 0, q); check("lb_rbr", {24'd0, q}, 32'h3C);
        repeat (2) @(posedge clk); #1;
        check("lb_int_lo", {31'd0, irq[1]}, 32'h0);
        wb_read(2, 5, q); check("lb_lsr_dr", {31'd0, q[0]}, 32'h0);
        repeat (20) @(posedge clk);

        // Overrun: two bytes, no read in between
        wb_write(2, 1, 8'h07);
        wb_write(2, 0, 8'h11);
        wb_write(2, 0, 8'h22);
        repeat (400) @(posedge clk);
        wb_read(2, 2, q); check("ovr_iir", {24'd0, q}, 32'h06);
        wb_read(2, 5, q); check("ovr_lsr", {24'd0, q}, 32'h63);
        wb_read(2, 5, q); check("ovr_lsr_clr", {24'd0, q}, 32'h61);
        wb_read(2, 0, q); check("ovr_rbr", {24'd0, q}, 32'h22);
        wb_read(2, 2, q); check("thre_iir", {24'd0, q}, 32'h02);
        wb_read(2, 2, q); check("thre_iir_clr", {24'd0, q}, 32'h01);

        // Framing error: stop bit driven low
        lb = 1'b0;
        send_raw(8'h5A, 1'b0);
        wb_read(2, 2, q); check("fe_iir", {24'd0, q}, 32'h06);
        wb_read(2, 5, q); check("fe_lsr", {24'd0, q}, 32'h69);
        wb_read(2, 5, q); check("fe_lsr_clr", {24'd0, q}, 32'h61);
        wb_read(2, 0, q); check("fe_rbr", {24'd0, q}, 32'h5A);

        // Modem lines on channel 3 (bit 0)
        wb_write(3, 4, 8'h03);
        repeat (2) @(posedge clk); #1;
        check("mdm_rts", {28'd0, rts}, 32'hE);
        check("mdm_dtr", {28'd0, dtr}, 32'hE);
        cts = 4'hE;
        wb_read(3, 6, q); check("mdm_msr3", {24'd0, q}, 32'h10);
        wb_read(0, 6, q); check("mdm_msr0", {24'd0, q}, 32'h00);
        cts = 4'hF;

        // Held strobe: acks alternate
        @(posedge clk); #1;
        adr = {25'd0, 2'd1, 3'd7, 2'b00};
        we  = 1'b0;
        sel = 4'hF;
        cyc = 1'b1;
        stb = 1'b1;
        check("hold_ack0", {31'd0, ack}, 32'd0);
        @(posedge clk); #1; check("hold_ack1", {31'd0, ack}, 32'd1);
        @(posedge clk); #1; check("hold_ack2", {31'd0, ack}, 32'd0);
        @(posedge clk); #1; check("hold_ack3", {31'd0, ack}, 32'd1);
        cyc = 1'b0;
        stb = 1'b0;

        // Byte select gating and the unused offset
        wb_xfer(1, 1, 1'b1, 8'h05, 4'h0, q);
        wb_read(1, 1, q); check("sel0_ier", {24'd0, q}, 32'h00);
        wb_xfer(1, 1, 1'b1, 8'h05, 4'h1, q);
        wb_read(1, 1, q); check("sel1_ier", {24'd0, q}, 32'h05);
        wb_write(1, 7, 8'hFF);
        wb_read(1, 7, q); check("reg7", {24'd0, q}, 32'h00);

        // Reset in the middle of a frame
        wb_write(0, 0, 8'h00);
        repeat (30) @(posedge clk); #1;
        check("mid_tx_low", {31'd0, tx[3]}, 32'd0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_tx", {28'd0, tx}, 32'hF);
        check("mid_rst_rts", {28'd0, rts}, 32'hF);
        repeat (2) @(posedge clk);
        rst_n = 1'b1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
